// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage -- MEM/WB pipeline register and write-back stage.
//
// Captures the MEM-stage instruction and drives the register-file write port
// (WA/WE/WD) one cycle later. It also formats load data (LB/LBU/LH/LHU/LW),
// counts retired instructions, and forwards data to the decode-stage operands.
//
// Optional feature: define WB_BYPASS_EN to forward the write-back value to
// BYP_RD1/BYP_RD2 when the write address matches RA1/RA2 (write-before-read).
// Without the macro, the BYP_RDx outputs pass RF_RDx straight through.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   stall, flush        hold the stage / load a bubble (stall wins)
//   in_valid .. in_load_type   MEM-stage instruction fields
//   RA1, RA2            decode-stage read addresses
//   RF_RD1, RF_RD2      raw register-file read data
//   WA, WE, WD          register-file write port
//   BYP_RD1, BYP_RD2    operand data returned to decode
//   retired_cnt         retired-instruction counter (wraps)
// -----------------------------------------------------------------------------
module wb_stage #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             in_reg_write,
    input  logic             in_mem_to_reg,
    input  logic [4:0]       in_dest,
    input  logic [31:0]      in_alu_result,
    input  logic [31:0]      in_mem_data,
    input  logic [2:0]       in_load_type,
    input  logic [4:0]       RA1,
    input  logic [4:0]       RA2,
    input  logic [31:0]      RF_RD1,
    input  logic [31:0]      RF_RD2,
    output logic [4:0]       WA,
    output logic             WE,
    output logic [31:0]      WD,
    output logic [31:0]      BYP_RD1,
    output logic [31:0]      BYP_RD2,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam logic [2:0] LT_LB  = 3'd1;
    localparam logic [2:0] LT_LBU = 3'd2;
    localparam logic [2:0] LT_LH  = 3'd3;
    localparam logic [2:0] LT_LHU = 3'd4;

    // Stage registers
    logic             valid_q,       valid_d;
    logic             reg_write_q,   reg_write_d;
    logic             mem_to_reg_q,  mem_to_reg_d;
    logic [4:0]       dest_q,        dest_d;
    logic [31:0]      alu_result_q,  alu_result_d;
    logic [31:0]      mem_data_q,    mem_data_d;
    logic [2:0]       load_type_q,   load_type_d;
    logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;

    // Next-state logic
    always_comb begin
        valid_d       = valid_q;
        reg_write_d   = reg_write_q;
        mem_to_reg_d  = mem_to_reg_q;
        dest_d        = dest_q;
        alu_result_d  = alu_result_q;
        mem_data_d    = mem_data_q;
        load_type_d   = load_type_q;
        retired_cnt_d = retired_cnt_q;

        if (!stall) begin
            // The instruction currently held retires on this edge.
            if (valid_q) begin
                retired_cnt_d = retired_cnt_q + CNT_W'(1);
            end
            // Fields are captured even on flush; only valid matters then.
            valid_d      = in_valid & ~flush;
            reg_write_d  = in_reg_write;
            mem_to_reg_d = in_mem_to_reg;
            dest_d       = in_dest;
            alu_result_d = in_alu_result;
            mem_data_d   = in_mem_data;
            load_type_d  = in_load_type;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q       <= 1'b0;
            reg_write_q   <= 1'b0;
            mem_to_reg_q  <= 1'b0;
            dest_q        <= 5'd0;
            alu_result_q  <= 32'd0;
            mem_data_q    <= 32'd0;
            load_type_q   <= 3'd0;
            retired_cnt_q <= '0;
        end else begin
            valid_q       <= valid_d;
            reg_write_q   <= reg_write_d;
            mem_to_reg_q  <= mem_to_reg_d;
            dest_q        <= dest_d;
            alu_result_q  <= alu_result_d;
            mem_data_q    <= mem_data_d;
            load_type_q   <= load_type_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    // Load formatting: the low two ALU-result bits select the byte lane;
    // halfword loads use only bit 1 (bit 0 is ignored, no misalignment trap).
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;

    always_comb begin
        load_byte = 8'd0;
        load_half = 16'd0;
        load_data = mem_data_q;

        case (alu_result_q[1:0])
            2'd0:    load_byte = mem_data_q[7:0];
            2'd1:    load_byte = mem_data_q[15:8];
            2'd2:    load_byte = mem_data_q[23:16];
            default: load_byte = mem_data_q[31:24];
        endcase

        load_half = alu_result_q[1] ? mem_data_q[31:16] : mem_data_q[15:0];

        case (load_type_q)
            LT_LB:   load_data = {{24{load_byte[7]}}, load_byte};
            LT_LBU:  load_data = {24'd0, load_byte};
            LT_LH:   load_data = {{16{load_half[15]}}, load_half};
            LT_LHU:  load_data = {16'd0, load_half};
            default: load_data = mem_data_q;   // LW and reserved encodings
        endcase
    end

    // Write port. Writes to x0 are suppressed here, which also guarantees
    // that RAx = 0 can never pick up a forwarded value.
    assign WA = dest_q;
    assign WE = valid_q & reg_write_q & (dest_q != 5'd0);
    assign WD = mem_to_reg_q ? load_data : alu_result_q;

    assign retired_cnt = retired_cnt_q;

`ifdef WB_BYPASS_EN
    assign BYP_RD1 = (WE && (WA == RA1)) ? WD : RF_RD1;
    assign BYP_RD2 = (WE && (WA == RA2)) ? WD : RF_RD2;
`else
    // No forwarding: read addresses are intentionally left unconnected.
    logic unused_ra;
    assign unused_ra = ^{RA1, RA2};
    assign BYP_RD1   = RF_RD1;
    assign BYP_RD2   = RF_RD2;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage -- directed self-checking bench for wb_stage.
// Inputs change 1 ns after a rising edge; outputs are checked in the same
// window, away from the clock edge. A one-bit shadow of the captured valid
// flag, plus a counter, gives the expected retired count.
// -----------------------------------------------------------------------------
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush;
    logic        in_valid, in_reg_write, in_mem_to_reg;
    logic [4:0]  in_dest;
    logic [31:0] in_alu_result, in_mem_data;
    logic [2:0]  in_load_type;
    logic [4:0]  RA1, RA2;
    logic [31:0] RF_RD1, RF_RD2;
    logic [4:0]  WA;
    logic        WE;
    logic [31:0] WD, BYP_RD1, BYP_RD2;
    logic [31:0] retired_cnt;

    int checks   = 0;
    int failures = 0;

    // Bench-side model of the retire bookkeeping
    logic        m_valid;
    logic [31:0] m_cnt;
    logic [31:0] held_cnt;

    always #5 clk = ~clk;

    wb_stage #(.CNT_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_reg_write  (in_reg_write),
        .in_mem_to_reg (in_mem_to_reg),
        .in_dest       (in_dest),
        .in_alu_result (in_alu_result),
        .in_mem_data   (in_mem_data),
        .in_load_type  (in_load_type),
        .RA1           (RA1),
        .RA2           (RA2),
        .RF_RD1        (RF_RD1),
        .RF_RD2        (RF_RD2),
        .WA            (WA),
        .WE            (WE),
        .WD            (WD),
        .BYP_RD1       (BYP_RD1),
        .BYP_RD2       (BYP_RD2),
        .retired_cnt   (retired_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    // Advance one rising edge, updating the model from the inputs in force.
    task automatic step();
        if (!stall) begin
            if (m_valid) m_cnt = m_cnt + 32'd1;
            m_valid = in_valid & ~flush;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_cnt   = 32'd0;
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; in_valid = 0; in_reg_write = 0; in_mem_to_reg = 0;
        in_dest = 0; in_alu_result = 0; in_mem_data = 0; in_load_type = 0;
    endtask

    // One load through the stage, checking the formatted write data.
    task automatic do_load(input string tag, input logic [2:0] lt, input logic [1:0] off,
                           input logic [31:0] exp);
        in_valid = 1; in_reg_write = 1; in_mem_to_reg = 1; in_dest = 5'd3;
        in_alu_result = {30'h1000_0000, off}; in_mem_data = 32'h80FF_7F01;
        in_load_type = lt;
        step();
        check(tag, WD, exp);
    endtask

    initial begin
        idle_inputs();
        RA1 = 0; RA2 = 0; RF_RD1 = 0; RF_RD2 = 0;
        model_reset();

        // Reset state
        rst_n = 0;
        #3;
        check("rst_we", {31'd0, WE}, 32'd0);
        check("rst_wa", {27'd0, WA}, 32'd0);
        check("rst_wd", WD, 32'd0);
        check("rst_cnt", retired_cnt, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1;
        @(posedge clk); #1;
        check("post_rst_we", {31'd0, WE}, 32'd0);
        check("post_rst_cnt", retired_cnt, 32'd0);

        // ALU op to x5
        in_valid = 1; in_reg_write = 1; in_mem_to_reg = 0; in_dest = 5'd5;
        in_alu_result = 32'h1234_5678;
        step();
        check("alu_we", {31'd0, WE}, 32'd1);
        check("alu_wa", {27'd0, WA}, 32'd5);
        check("alu_wd", WD, 32'h1234_5678);
        check("alu_cnt_before", retired_cnt, 32'd0);
        idle_inputs();
        step();
        check("alu_cnt_after", retired_cnt, 32'd1);
        check("bubble_we", {31'd0, WE}, 32'd0);

        // Load formatting
        do_load("lb_off3",  3'd1, 2'd3, 32'hFFFF_FF80);
        do_load("lbu_off3", 3'd2, 2'd3, 32'h0000_0080);
        do_load("lh_off2",  3'd3, 2'd2, 32'hFFFF_80FF);
        do_load("lhu_off1", 3'd4, 2'd1, 32'h0000_7F01);
        do_load("lb_off0",  3'd1, 2'd0, 32'h0000_0001);
        do_load("lb_off1",  3'd1, 2'd1, 32'h0000_007F);
        do_load("lbu_off2", 3'd2, 2'd2, 32'h0000_00FF);
        do_load("lh_off3",  3'd3, 2'd3, 32'hFFFF_80FF);
        do_load("lw",       3'd0, 2'd2, 32'h80FF_7F01);
        do_load("lt6_as_lw", 3'd6, 2'd3, 32'h80FF_7F01);
        check("load_we", {31'd0, WE}, 32'd1);
        check("load_cnt", retired_cnt, m_cnt);

        // Write to x0: suppressed but still retired
        in_valid = 1; in_reg_write = 1; in_mem_to_reg = 0; in_dest = 5'd0;
        in_alu_result = 32'hDEAD_BEEF;
        step();
        check("x0_we", {31'd0, WE}, 32'd0);
        held_cnt = retired_cnt;
        idle_inputs();
        step();
        check("x0_cnt_inc", retired_cnt, held_cnt + 32'd1);
        check("x0_cnt_model", retired_cnt, m_cnt);

        // Valid instruction without reg_write
        in_valid = 1; in_reg_write = 0; in_dest = 5'd6; in_alu_result = 32'h1;
        step();
        check("nowr_we", {31'd0, WE}, 32'd0);

        // Stall + flush held for 3 cycles
        in_valid = 1; in_reg_write = 1; in_mem_to_reg = 0; in_dest = 5'd7;
        in_alu_result = 32'h0000_0777;
        step();
        check("stall_cap_we", {31'd0, WE}, 32'd1);
        held_cnt = retired_cnt;
        stall = 1; flush = 1; in_dest = 5'd9; in_alu_result = 32'h9999_9999;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall%0d_wa", i), {27'd0, WA}, 32'd7);
            check($sformatf("stall%0d_we", i), {31'd0, WE}, 32'd1);
            check($sformatf("stall%0d_wd", i), WD, 32'h0000_0777);
            check($sformatf("stall%0d_cnt", i), retired_cnt, held_cnt);
        end
        stall = 0; flush = 0; in_valid = 0;
        step();
        check("unstall_we", {31'd0, WE}, 32'd0);
        check("unstall_cnt", retired_cnt, held_cnt + 32'd1);

        // Flush without stall yields a bubble
        in_valid = 1; in_reg_write = 1; in_dest = 5'd8; flush = 1;
        step();
        check("flush_we", {31'd0, WE}, 32'd0);
        flush = 0; in_valid = 0;
        step();
        check("flush_cnt", retired_cnt, m_cnt);

        // Bypass
        in_valid = 1; in_reg_write = 1; in_mem_to_reg = 0; in_dest = 5'd9;
        in_alu_result = 32'hAAAA_5555;
        step();
        RA1 = 5'd9; RF_RD1 = 32'd0; RA2 = 5'd4; RF_RD2 = 32'h1111_2222;
        #1;
`ifdef WB_BYPASS_EN
        check("byp_rd1_hit", BYP_RD1, 32'hAAAA_5555);
`else
        check("byp_rd1_hit", BYP_RD1, 32'd0);
`endif
        check("byp_rd2_miss", BYP_RD2, 32'h1111_2222);
        RA1 = 5'd0; RF_RD1 = 32'h0000_0055; RA2 = 5'd9; RF_RD2 = 32'h0BAD_0BAD;
        #1;
        check("byp_rd1_x0", BYP_RD1, 32'h0000_0055);
`ifdef WB_BYPASS_EN
        check("byp_rd2_hit", BYP_RD2, 32'hAAAA_5555);
`else
        check("byp_rd2_hit", BYP_RD2, 32'h0BAD_0BAD);
`endif
        idle_inputs();
        step();
        RA2 = 5'd9;
        #1;
        check("byp_rd2_nowe", BYP_RD2, 32'h0BAD_0BAD);

        // Asynchronous reset mid-cycle while WE=1
        in_valid = 1; in_reg_write = 1; in_dest = 5'd5; in_alu_result = 32'h5555_0000;
        step();
        check("arst_pre_we", {31'd0, WE}, 32'd1);
        #2;
        rst_n = 0;
        model_reset();
        #1;
        check("arst_we", {31'd0, WE}, 32'd0);
        check("arst_wa", {27'd0, WA}, 32'd0);
        check("arst_wd", WD, 32'd0);
        check("arst_cnt", retired_cnt, 32'd0);
        @(posedge clk); #3;
        rst_n = 1;
        idle_inputs();
        step();
        check("arst_rel_we", {31'd0, WE}, 32'd0);

        // Reset while stalled discards the held instruction
        in_valid = 1; in_reg_write = 1; in_dest = 5'd12; in_alu_result = 32'hC;
        step();
        stall = 1;
        step();
        check("rstall_pre_we", {31'd0, WE}, 32'd1);
        #2;
        rst_n = 0;
        model_reset();
        #2;
        rst_n = 1;
        idle_inputs();
        step();
        check("rstall_we", {31'd0, WE}, 32'd0);
        step();
        check("rstall_cnt", retired_cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
